// File: rtl/tt_trng_pkg.sv
// tt_trng_pkg: shared types and constants for the ring-oscillator TRNG sequencer.
// Holds the FSM state enum, default parameter values and counter widths.

package tt_trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_VALID   = 3'd3,
        ST_PULSE   = 3'd4,
        ST_FAIL    = 3'd5
    } trng_state_t;

    localparam int WARMUP_CYC_DEF = 64;
    localparam int KEY_W_DEF      = 4;
    localparam int RCT_LIMIT_DEF  = 8;
    localparam int PULSE_CYC_DEF  = 4;

    localparam int WARMUP_CYC_MAX = 1023;
    localparam int RCT_LIMIT_MAX  = 31;

    // One shared cycle counter serves warm-up, collection and pulse timing;
    // warm-up is the longest of the three.
    localparam int CNT_W = $clog2(WARMUP_CYC_MAX + 1);

    // Repetition-count run length, saturating at the largest legal limit.
    localparam int RUN_W = $clog2(RCT_LIMIT_MAX + 1);

endpackage

// File: rtl/tt_rct_monitor.sv
// tt_rct_monitor: repetition-count health test on the raw ring bit.
// Counts identical consecutive samples while enabled; hit flags a run at or
// above the limit. Built into tt_trng_ctrl only when TRNG_CTRL_RCT_EN is defined.
// Reset is active-high despite the rst_n name.

module tt_rct_monitor
    import tt_trng_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             bit_in,
    input  logic [RUN_W-1:0] limit,
    output logic             hit
);

    logic             prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;

    // Next run length: restart on the first sample or a change, saturate on repeats.
    always_comb begin
        prev_d = prev_q;
        run_d  = run_q;
        if (!en) begin
            run_d = '0;
        end else begin
            prev_d = bit_in;
            if ((run_q == '0) || (bit_in != prev_q)) begin
                run_d = RUN_W'(1);
            end else if (run_q != '1) begin
                run_d = run_q + 1'b1;
            end
        end
    end

    // Sample history and run length registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            prev_q <= 1'b0;
            run_q  <= '0;
        end else begin
            prev_q <= prev_d;
            run_q  <= run_d;
        end
    end

    // Decoded from the registered run so the FSM reacts on the following edge.
    assign hit = (run_q >= limit);

endmodule

// File: rtl/tt_trng_ctrl.sv
// tt_trng_ctrl: sequencer for the ring-oscillator entropy path.
// Warms up the rings, shifts in a KEY_W-bit key, hands it over on valid/ready,
// then fires a PULSE_CYC-wide challenge strobe.
// Optional build macro TRNG_CTRL_RCT_EN adds the repetition-count health
// monitor and the sticky FAIL state; without it health_fail stays 0.
// Reset is asynchronous and active-high despite the rst_n name.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | rings off, waiting for req
// WARMUP  | rings on, letting them settle for WARMUP_CYC cycles
// COLLECT | rings on, shifting KEY_W raw bits into key (first at MSB)
// VALID   | rings off, key_valid high until key_ready
// PULSE   | challenge strobe high for PULSE_CYC cycles
// FAIL    | stuck source detected; only reset leaves

module tt_trng_ctrl
    import tt_trng_pkg::*;
#(
    parameter int WARMUP_CYC = WARMUP_CYC_DEF,
    parameter int KEY_W      = KEY_W_DEF,
    parameter int RCT_LIMIT  = RCT_LIMIT_DEF,
    parameter int PULSE_CYC  = PULSE_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             bit_in,
    output logic             ring_en,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             pulse,
    output logic             busy,
    output logic             health_fail
);

    localparam logic [CNT_W-1:0] WARMUP_TC = CNT_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W-1:0] COLLECT_TC = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] PULSE_TC  = CNT_W'(PULSE_CYC - 1);

    trng_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             ring_en_q, ring_en_d;
    logic             key_valid_q, key_valid_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             health_fail_q, health_fail_d;
    logic             rct_hit;

`ifdef TRNG_CTRL_RCT_EN
    tt_rct_monitor u_rct_monitor (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (ring_en_q),
        .bit_in (bit_in),
        .limit  (RUN_W'(RCT_LIMIT)),
        .hit    (rct_hit)
    );
`else
    // Legal limits are at least 2, so without the monitor this never trips.
    assign rct_hit = (RCT_LIMIT == 0);
`endif

    // Next state, shared counter, key shift register and decoded outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_WARMUP;
                    cnt_d   = '0;
                end
            end
            ST_WARMUP: begin
                if (cnt_q == WARMUP_TC) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COLLECT: begin
                key_d = {key_q[KEY_W-2:0], bit_in};
                if (cnt_q == COLLECT_TC) begin
                    state_d = ST_VALID;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_VALID: begin
                if (key_ready) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_TC) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A health hit overrides every transition, including the last shift,
        // so a suspect key is never presented.
        if (rct_hit && (state_q != ST_IDLE) && (state_q != ST_FAIL)) begin
            state_d = ST_FAIL;
            cnt_d   = '0;
        end

        ring_en_d     = (state_d == ST_WARMUP) || (state_d == ST_COLLECT);
        key_valid_d   = (state_d == ST_VALID);
        pulse_d       = (state_d == ST_PULSE);
        busy_d        = (state_d != ST_IDLE);
        health_fail_d = (state_d == ST_FAIL);
    end

    // FSM state, counter, key and registered outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            key_q         <= '0;
            ring_en_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            pulse_q       <= 1'b0;
            busy_q        <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_q         <= key_d;
            ring_en_q     <= ring_en_d;
            key_valid_q   <= key_valid_d;
            pulse_q       <= pulse_d;
            busy_q        <= busy_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign ring_en     = ring_en_q;
    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign pulse       = pulse_q;
    assign busy        = busy_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_tt_trng_ctrl.sv
// tb_tt_trng_ctrl: directed bench for tt_trng_ctrl with default parameters.
// Expectations for the stuck-source case follow TRNG_CTRL_RCT_EN.

module tb_tt_trng_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req = 1'b0;
    logic       bit_in = 1'b0;
    logic       key_ready = 1'b0;
    logic       ring_en;
    logic [3:0] key;
    logic       key_valid;
    logic       pulse;
    logic       busy;
    logic       health_fail;

    int n_pass = 0;
    int n_total = 0;
    bit alt_mode = 1'b1;

    tt_trng_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .bit_in      (bit_in),
        .ring_en     (ring_en),
        .key         (key),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .pulse       (pulse),
        .busy        (busy),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (alt_mode) bit_in = ~bit_in;
        else          bit_in = 1'b1;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_ring_en"},     ring_en,     0);
        check({pfx, "_key"},         key,         0);
        check({pfx, "_key_valid"},   key_valid,   0);
        check({pfx, "_pulse"},       pulse,       0);
        check({pfx, "_busy"},        busy,        0);
        check({pfx, "_health_fail"}, health_fail, 0);
    endtask

    // One-cycle req; bit_in chosen so the first post-req sample is 1.
    task automatic start_key(input bit alt);
        alt_mode = alt;
        bit_in   = alt ? 1'b0 : 1'b1;
        req      = 1'b1;
        step();
        req      = 1'b0;
    endtask

    // Count cycles after the req edge until key_valid; optional stray pulses.
    task automatic wait_valid(input int req_at, input int rdy_at, output int lat, output int ring_hi);
        lat = 0;
        ring_hi = 0;
        while (!key_valid && lat < 200) begin
            if (ring_en) ring_hi++;
            req       = (lat == req_at);
            key_ready = (lat == rdy_at);
            step();
            lat++;
        end
        req = 1'b0;
        key_ready = 1'b0;
    endtask

    // Accept the key, then count pulse-high cycles.
    task automatic accept(input string pfx, output int pc);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        check({pfx, "_valid_fall"}, key_valid, 0);
        check({pfx, "_pulse_rise"}, pulse,     1);
        pc = 0;
        while (pulse && pc < 50) begin
            pc++;
            step();
        end
    endtask

    initial begin
        int lat, ring_hi, pc, bad;

        // Reset state
        repeat (3) step();
        check_reset("rst");
        rst_n = 1'b0;
        step();
        check_reset("post_rst");

        // Basic key with alternating source
        start_key(1'b1);
        check("s1_ring_on", ring_en, 1);
        check("s1_busy",    busy,    1);
        wait_valid(-1, -1, lat, ring_hi);
        check("s1_latency", lat,       68);
        check("s1_ring_hi", ring_hi,   68);
        check("s1_key",     key,       4'b1010);
        check("s1_ring_off", ring_en,  0);

        // Hold off key_ready for 20 cycles
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (key !== 4'b1010 || key_valid !== 1'b1 || pulse !== 1'b0) bad++;
        end
        check("s2_hold_stable", bad, 0);
        accept("s2", pc);
        check("s2_pulse_cycles", pc,   4);
        check("s2_busy_low",     busy, 0);
        step();
        check("s2_stay_idle", ring_en, 0);

        // Stray req in WARMUP and VALID, stray key_ready in COLLECT
        start_key(1'b1);
        wait_valid(10, 65, lat, ring_hi);
        check("s6_latency", lat,     68);
        check("s6_ring_hi", ring_hi, 68);
        check("s6_key",     key,     4'b1010);
        req = 1'b1;
        step();
        req = 1'b0;
        check("s6_valid_req_ignored", key_valid, 1);
        check("s6_valid_no_pulse",    pulse,     0);
        accept("s6", pc);
        check("s6_pulse_cycles", pc,   4);
        check("s6_busy_low",     busy, 0);
        step();
        check("s6_no_restart", busy, 0);

        // Reset during COLLECT
        start_key(1'b1);
        repeat (66) step();
        check("s5_in_collect", ring_en, 1);
        rst_n = 1'b1;
        #1;
        check_reset("s5_async");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        step();
        check_reset("s5_after");
        start_key(1'b1);
        wait_valid(-1, -1, lat, ring_hi);
        check("s5_latency", lat, 68);
        check("s5_key",     key, 4'b1010);
        accept("s5", pc);
        check("s5_pulse_cycles", pc, 4);

        // Stuck source from the start of WARMUP
        start_key(1'b0);
`ifdef TRNG_CTRL_RCT_EN
        lat = 0;
        bad = 0;
        while (!health_fail && lat < 100) begin
            if (key_valid) bad++;
            step();
            lat++;
        end
        check("s3_fail_latency", lat,       9);
        check("s3_health_fail",  health_fail, 1);
        check("s3_ring_off",     ring_en,   0);
        check("s3_busy",         busy,      1);
        for (int i = 0; i < 80; i++) begin
            step();
            if (key_valid || pulse || ring_en || !health_fail) bad++;
        end
        check("s3_stays_failed", bad, 0);
        rst_n = 1'b1;
        #1;
        check_reset("s3_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
`else
        wait_valid(-1, -1, lat, ring_hi);
        check("s4_latency",     lat,         68);
        check("s4_key",         key,         4'b1111);
        check("s4_health_fail", health_fail, 0);
        accept("s4", pc);
        check("s4_pulse_cycles", pc,          4);
        check("s4_health_after", health_fail, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
